// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the internal data bus arbiter.
// Lock support in bus_arbiter is built only when BUS_ARB_LOCK_EN is defined.
package bus_arb_pkg;

    localparam int unsigned DEFAULT_REQUESTER_COUNT = 4;
    localparam int unsigned DEFAULT_WIDTH           = 8;
    localparam int unsigned DEFAULT_MAX_HOLD        = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOCKED
    } arb_state_t;

    // Wrapping increment of a requester index.
    function automatic int unsigned next_index(input int unsigned idx, input int unsigned count);
        return (idx + 1 >= count) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr, ascending with wrap.
module rr_priority_picker
    import bus_arb_pkg::*;
#(
    parameter int unsigned REQUESTER_COUNT = DEFAULT_REQUESTER_COUNT,
    parameter int unsigned IDX_BITS        = $clog2(REQUESTER_COUNT)
) (
    input  logic [REQUESTER_COUNT-1:0] req,
    input  logic [IDX_BITS-1:0]        ptr,
    output logic [REQUESTER_COUNT-1:0] winner,
    output logic [IDX_BITS-1:0]        winner_index,
    output logic                       any_req
);

    int unsigned cand;

    always_comb begin
        winner       = '0;
        winner_index = '0;
        any_req      = 1'b0;
        cand         = 0;
        for (int unsigned i = 0; i < REQUESTER_COUNT; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= REQUESTER_COUNT) begin
                cand = cand - REQUESTER_COUNT;
            end
            if (!any_req && req[cand]) begin
                any_req      = 1'b1;
                winner[cand] = 1'b1;
                winner_index = IDX_BITS'(cand);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared internal data bus with registered grant and data.
// Define BUS_ARB_LOCK_EN to build the bounded lock (LOCKED state and hold counter).
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned REQUESTER_COUNT = DEFAULT_REQUESTER_COUNT,
    parameter int unsigned WIDTH           = DEFAULT_WIDTH,
    parameter int unsigned MAX_HOLD        = DEFAULT_MAX_HOLD,
    parameter int unsigned IDX_BITS        = $clog2(REQUESTER_COUNT)
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic [REQUESTER_COUNT-1:0]         req,
    input  logic [REQUESTER_COUNT-1:0]         lock,
    input  logic [REQUESTER_COUNT*WIDTH-1:0]   reqData,
    output logic [REQUESTER_COUNT-1:0]         grant,
    output logic [IDX_BITS-1:0]                grantIndex,
    output logic [WIDTH-1:0]                   busData,
    output logic                               busValid
);

    arb_state_t                 state_q;
    logic [IDX_BITS-1:0]        ptr_q;

    logic [REQUESTER_COUNT-1:0] pick_onehot;
    logic [IDX_BITS-1:0]        pick_index;
    logic                       any_req;
    logic [IDX_BITS-1:0]        ptr_next;
    logic [WIDTH-1:0]           pick_data;

    rr_priority_picker #(
        .REQUESTER_COUNT (REQUESTER_COUNT),
        .IDX_BITS        (IDX_BITS)
    ) u_picker (
        .req          (req),
        .ptr          (ptr_q),
        .winner       (pick_onehot),
        .winner_index (pick_index),
        .any_req      (any_req)
    );

    assign pick_data = reqData[pick_index*WIDTH +: WIDTH];
    assign ptr_next  = IDX_BITS'(next_index(32'(pick_index), REQUESTER_COUNT));

`ifdef BUS_ARB_LOCK_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_q;
    logic              lock_hold;
    logic [WIDTH-1:0]  held_data;

    // Only the current grantee may extend; the final allowed cycle forces re-arbitration.
    assign lock_hold = (state_q != IDLE) && req[grantIndex] && lock[grantIndex] &&
                       (hold_q < HOLD_W'(MAX_HOLD - 1));
    assign held_data = reqData[grantIndex*WIDTH +: WIDTH];
`else
    logic unused_lock;
    assign unused_lock = ^{lock, state_q == LOCKED};
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant      <= '0;
            grantIndex <= '0;
            busData    <= '0;
            busValid   <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
            hold_q     <= '0;
`endif
        end else begin
`ifdef BUS_ARB_LOCK_EN
            if (lock_hold) begin
                // Grant, index and pointer stay put; only the data is re-sampled.
                state_q <= LOCKED;
                busData <= held_data;
                hold_q  <= hold_q + HOLD_W'(1);
            end else
`endif
            if (any_req) begin
                state_q    <= GRANT;
                ptr_q      <= ptr_next;
                grant      <= pick_onehot;
                grantIndex <= pick_index;
                busData    <= pick_data;
                busValid   <= 1'b1;
`ifdef BUS_ARB_LOCK_EN
                hold_q     <= '0;
`endif
            end else begin
                state_q    <= IDLE;
                grant      <= '0;
                grantIndex <= '0;
                busValid   <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
                hold_q     <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: per-cycle reference model plus directed literal checks.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;
`ifdef BUS_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk;
    logic           nrst;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   grant;
    logic [1:0]     grantIndex;
    logic [W-1:0]   busData;
    logic           busValid;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter #(
        .REQUESTER_COUNT (N),
        .WIDTH           (W),
        .MAX_HOLD        (MH),
        .IDX_BITS        (2)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req        (req),
        .lock       (lock),
        .reqData    (reqData),
        .grant      (grant),
        .grantIndex (grantIndex),
        .busData    (busData),
        .busValid   (busValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, where the next search starts, burst length so far.
    typedef struct {
        int unsigned ptr;
        int unsigned owner;
        int unsigned run;
        bit          valid;
        logic [7:0]  data;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.ptr = 0; m.owner = 0; m.run = 0; m.valid = 1'b0; m.data = 8'h00;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input logic [N-1:0] r,
                                          input logic [N-1:0] l, input logic [N*W-1:0] d);
        model_t nx;
        bit     found;
        nx    = m;
        found = 1'b0;
        if (LOCK_EN && m.valid && r[m.owner] && l[m.owner] && m.run < MH) begin
            nx.run  = m.run + 1;
            nx.data = d[m.owner*W +: W];
        end else begin
            for (int k = 0; k < N; k++) begin
                int unsigned c;
                c = (m.ptr + k) % N;
                if (!found && r[c]) begin
                    found    = 1'b1;
                    nx.owner = c;
                end
            end
            if (found) begin
                nx.valid = 1'b1;
                nx.run   = 1;
                nx.data  = d[nx.owner*W +: W];
                nx.ptr   = (nx.owner + 1) % N;
            end else begin
                nx.valid = 1'b0;
                nx.owner = 0;
                nx.run   = 0;
            end
        end
        return nx;
    endfunction

    model_t m = model_reset();

    always @(posedge clk or negedge nrst) begin
        if (!nrst) m <= model_reset();
        else       m <= model_step(m, req, lock, reqData);
    end

    always @(negedge clk) begin
        check("model_grant", 32'(grant), m.valid ? (32'd1 << m.owner) : 32'd0);
        check("model_index", 32'(grantIndex), m.valid ? 32'(m.owner) : 32'd0);
        check("model_valid", 32'(busValid), 32'(m.valid));
        check("model_data", 32'(busData), 32'(m.data));
    end

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d);
        @(negedge clk);
        req     = r;
        lock    = l;
        reqData = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 nrst = 1'b0;
        @(negedge clk);
        #2 nrst = 1'b1;
    endtask

    logic [N-1:0] rot_exp  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [W-1:0] rot_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`ifdef BUS_ARB_LOCK_EN
    logic [N-1:0] lock_exp [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
`else
    logic [N-1:0] lock_exp [6] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
    logic [2*N-1:0] vec [16] = '{
        8'b1010_1000, 8'b1010_1000, 8'b1010_0000, 8'b0101_0100,
        8'b0101_0100, 8'b0101_0001, 8'b0000_1111, 8'b1111_1111,
        8'b1111_1111, 8'b1111_1111, 8'b1111_1111, 8'b1111_1111,
        8'b0001_0001, 8'b0001_0001, 8'b0001_0001, 8'b0001_0001
    };

    initial begin
        nrst    = 1'b0;
        req     = 4'b1111;
        lock    = 4'b0000;
        reqData = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_index", 32'(grantIndex), 32'h0);
        check("reset_data", 32'(busData), 32'h0);
        check("reset_valid", 32'(busValid), 32'h0);
        @(negedge clk);
        #2 nrst = 1'b1;

        drive(4'b0010, 4'b0000, 32'h7766_A555);
        check("single_grant", 32'(grant), 32'h2);
        check("single_index", 32'(grantIndex), 32'h1);
        check("single_data", 32'(busData), 32'hA5);
        check("single_valid", 32'(busValid), 32'h1);
        drive(4'b0000, 4'b0000, 32'h0102_0304);
        check("drop_valid", 32'(busValid), 32'h0);
        check("drop_data", 32'(busData), 32'hA5);
        check("drop_grant", 32'(grant), 32'h0);

        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b0000, 32'h4433_2211);
            check($sformatf("rot_grant%0d", i), 32'(grant), 32'(rot_exp[i]));
            check($sformatf("rot_data%0d", i), 32'(busData), 32'(rot_data[i]));
        end
        drive(4'b0000, 4'b0000, 32'h0);

        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            drive(4'b0011, 4'b0001, {24'h0, 8'(8'h40 + i)} | 32'h0000_AA00);
            check($sformatf("lock_grant%0d", i), 32'(grant), 32'(lock_exp[i]));
        end
        drive(4'b0000, 4'b0000, 32'h0);

        pulse_reset();
        drive(4'b0011, 4'b0001, 32'h0000_5A3C);
        drive(4'b0011, 4'b0001, 32'h0000_5A3D);
        #1 nrst = 1'b0;
        #1;
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_index", 32'(grantIndex), 32'h0);
        check("midrst_data", 32'(busData), 32'h0);
        check("midrst_valid", 32'(busValid), 32'h0);
        @(negedge clk);
        #2 nrst = 1'b1;
        drive(4'b0110, 4'b0000, 32'h0099_8800);
        check("after_rst_grant", 32'(grant), 32'h2);
        check("after_rst_index", 32'(grantIndex), 32'h1);
        drive(4'b0110, 4'b0000, 32'h0099_8800);
        check("after_rst_grant2", 32'(grant), 32'h4);

        for (int i = 0; i < 16; i++) begin
            drive(vec[i][2*N-1:N], vec[i][N-1:0], 32'($urandom));
        end
        drive(4'b0000, 4'b0000, 32'h0);
        drive(4'b0000, 4'b0000, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared internal data bus. Up to REQUESTER_COUNT sources (ALU result, PC halves, index registers, etc.) compete to drive the bus. The block grants one per cycle and presents the winner's byte as a registered bus value, with a valid strobe. Destination registers qualify their read enables with that strobe. An optional lock lets a source hold the bus for a bounded multi-cycle burst.

## Interface
- REQUESTER_COUNT, 4: number of competing sources (≥2)
- WIDTH, 8: bus width in bits
- MAX_HOLD, 4: maximum consecutive grant cycles for one locked source (≥1)
- IDX_BITS, $clog2(REQUESTER_COUNT): width of grantIndex
- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset, asynchronous, active-low
- req  in  REQUESTER_COUNT  source i requests the bus this cycle
- lock  in  REQUESTER_COUNT  source i asks to keep its grant next cycle
- reqData  in  REQUESTER_COUNT*WIDTH  packed data; source i at [WIDTH*(i+1)-1:WIDTH*i]
- grant  out  REQUESTER_COUNT  registered one-hot grant, all-zero when idle
- grantIndex  out  IDX_BITS  binary index of current grant, 0 when idle
- busData  out  WIDTH  registered data of granted source
- busValid  out  1  busData is a valid transfer this cycle

## Operation
- States: IDLE (no grant), GRANT (single-cycle grant), LOCKED (held grant, holdCount active).
- Round-robin pointer ptr: search starts at index ptr, ascending, wraps REQUESTER_COUNT-1 → 0. After granting source g, ptr ← (g+1) mod REQUESTER_COUNT.
- Each cycle in IDLE/GRANT: if |req, pick winner w, register grant=onehot(w), grantIndex=w, busData=reqData[w], busValid=1, next state GRANT. Otherwise grant=0, grantIndex=0, busValid=0, busData holds its last value, next state IDLE.
- A source holding req high keeps competing; it gets one cycle per round of the rotation.
- LOCKED entry: current grantee g has req[g]&lock[g] and holdCount < MAX_HOLD-1. Grant stays on g, busData re-samples reqData[g], holdCount++, ptr unchanged.
- Lock release: req[g] low, lock[g] low, or holdCount reaches MAX_HOLD-1. Normal arbitration runs that same cycle, with ptr = g+1. g may win again only if no other source requests.
- lock from a non-granted source is ignored. lock without req is ignored.
- holdCount resets to 0 on every new grantee and in IDLE.
- Reset values: grant=0, grantIndex=0, busData=0, busValid=0, ptr=0, holdCount=0, state IDLE.

## Timing
- Latency: req/reqData sampled on edge t; grant, busData and busValid are valid from t to t+1 (one cycle).
- One transfer per cycle with busValid high. No back-to-back bubble between different grantees.
- A locked burst of MAX_HOLD cycles is followed by at least one cycle to another requester, if any is pending.
- Asynchronous reset mid-burst clears all outputs immediately. First grant after release starts the search from index 0.
- Simultaneous release and new requests: release and re-arbitration resolve in the same edge, with no idle cycle.

## Configuration
- BUS_ARB_LOCK_EN defined: lock input, LOCKED state and holdCount are implemented as described.
- BUS_ARB_LOCK_EN undefined: lock port remains but is ignored. No LOCKED state and no holdCount are built. Every grant is single-cycle round-robin.

## Structure
- Package bus_arb_pkg: state enum typedef (IDLE, GRANT, LOCKED) and a default-parameter constant for REQUESTER_COUNT.
- Sub-module rr_priority_picker: combinational block taking req and ptr, returning a one-hot winner, its binary index and an any-request flag. The arbiter wraps this with the state, pointer, hold counter and output registers.

## Test plan
- Reset: nrst low with req=4'b1111 → grant=0000, grantIndex=0, busData=8'h00, busValid=0.
- Single request: req=0010, reqData[15:8]=8'hA5 → next cycle grant=0010, grantIndex=1, busData=8'hA5, busValid=1. Drop req → following cycle busValid=0, busData stays 8'hA5.
- Rotation: from reset, req=1111 held 5 cycles → grants 0001, 0010, 0100, 1000, 0001. Pointer wrap is verified.
- Lock burst (BUS_ARB_LOCK_EN, MAX_HOLD=4): req=0011, lock=0001 → grant 0001 for 4 cycles, then 0010, then 0001.
- Lock disabled, same stimulus → grants alternate 0001, 0010, 0001, 0010.
- Reset mid-burst: nrst low during the second locked cycle → all outputs 0 immediately. After release, req=0110 → first grant 0010.
